axi_ax_buffer: RTL
==================

// Module: axi_ax_buffer
// PURPOSE
//  Parametrised AXI4 address-channel (AR or AW) elastic buffer between slave and master sides.
//  Generalises the single-channel AR slice with AW/ATOP support, fall-through mode, a fill-level output and an optional stall counter.
//  Sits in AXI slice/crossbar paths wherever address-channel decoupling or timing cuts are needed.
// PARAMETERS
//  ID_WIDTH      4   AXI ID width (>=1)
//  ADDR_WIDTH    32  address width (>=1)
//  USER_WIDTH    1   user width (>=1)
//  BUFFER_DEPTH  2   FIFO entries; <1 is an elaboration $error
//  IS_AW         0   1: AW channel, ATOP (6b) stored; 0: AR, ATOP not stored
//  FALL_THROUGH  0   1: empty FIFO forwards push combinationally (0-cycle latency)
// PORTS
//  clk_i             in   1     clock
//  rst_ni            in   1     asynchronous reset, active low
//  test_en_i         in   1     test mode; no functional effect
//  slave_valid_i     in   1     slave AX valid
//  slave_addr_i      in   ADDR_WIDTH  address
//  slave_prot_i / region / len / size / burst / lock / cache / qos  in  3/4/8/3/2/1/4/4  AX attributes
//  slave_atop_i      in   6     atomic op; ignored when IS_AW=0
//  slave_id_i        in   ID_WIDTH    ID
//  slave_user_i      in   USER_WIDTH  user
//  slave_ready_o     out  1     slave AX ready
//  master_valid_o    out  1     master AX valid
//  master_addr_o ... master_user_o, master_atop_o  out  mirror of slave fields
//  master_ready_i    in   1     master AX ready
//  usage_o           out  $clog2(BUFFER_DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Payload = {cache,prot,lock,burst,size,len,qos,region,addr,user,id[,atop]}: 29+ADDR+USER+ID (+6 if IS_AW).
//  - push = slave_valid_i & slave_ready_o; pop = master_valid_o & master_ready_i.
//  - Reset (rst_ni low, async): usage_o=0, master_valid_o=0, slave_ready_o=0, all master_* data=0.
//    slave_ready_o rises on first clk edge after release (registered ready-enable flop).
//  - slave_ready_o = ready_en & (usage_o != BUFFER_DEPTH); no push accepted while full, even if pop same cycle.
//  - master_valid_o = (usage_o != 0), or FALL_THROUGH & empty & slave_valid_i & ready_en.
//  - Latency: FALL_THROUGH=0 -> 1 cycle push-to-valid; FALL_THROUGH=1 & empty -> 0 cycles, data = slave inputs.
//  - Fall-through push+pop when empty: bypass, no write, usage_o stays 0.
//  - Push+pop non-empty: write and read same cycle, usage_o unchanged, pointers both advance.
//  - Pointers wrap modulo BUFFER_DEPTH (non-power-of-2 supported via explicit compare-and-clear).
//  - Order strictly FIFO; master_* data stable while master_valid_o & !master_ready_i (AXI hold).
//  - master_atop_o tied 6'b0 when IS_AW=0.
//  - Reset mid-transfer drops all stored entries; no partial state survives.
// CONFIGURATION
//  Macro AXI_AX_BUFFER_STALL_CNT_EN:
//   defined: extra ports stall_clr_i (in,1) and stall_cnt_o (out,16); counter increments each cycle
//    master_valid_o & !master_ready_i, saturates at 16'hFFFF, stall_clr_i has priority (clears to 0), reset 0.
//   undefined: ports and counter absent; block otherwise identical.
// STRUCTURE
//  Package axi_ax_buffer_pkg: AX_FIXED_W=29, ATOP_W=6, function ax_payload_w(id,addr,user,is_aw).
//  Sub-module axi_ax_fifo #(DATA_WIDTH, DEPTH, FALL_THROUGH): storage, pointers, usage, ready/valid.
//  Top level: pack/unpack payload, ATOP gating, optional stall counter.
// TESTING
//  1 Reset, DEPTH=2: hold rst_ni low 3 cycles -> valid_o=0, ready_o=0, usage 0; ready_o=1 one cycle after release.
//  2 DEPTH=2, master_ready_i=0, push addr 0x100,0x200,0x300 -> first two accepted, usage 2, ready_o=0 on 3rd; release -> 0x100,0x200 in order.
//  3 DEPTH=3, continuous push/pop 10 beats, IDs 0..9 -> in-order output across pointer wrap, usage_o never >1 after startup.
//  4 FALL_THROUGH=1, empty, push id=5 with master_ready_i=1 -> master_valid_o same cycle, master_id_o=5, usage_o stays 0.
//  5 IS_AW=1 push atop=6'h21 -> master_atop_o=6'h21; IS_AW=0 same stimulus -> master_atop_o=0.
//  6 STALL_CNT_EN: hold valid with master_ready_i=0 for 20 cycles -> stall_cnt_o=20; stall_clr_i pulse -> 0; force saturation -> 16'hFFFF.

Source files
------------

// File: rtl/axi_ax_buffer_pkg.sv
// Shared widths, attribute bundle and payload-width helper for the AXI AX elastic buffer.
// The optional stall counter in axi_ax_buffer is enabled by defining AXI_AX_BUFFER_STALL_CNT_EN.
package axi_ax_buffer_pkg;

  localparam int AX_FIXED_W = 29;
  localparam int ATOP_W     = 6;

  // Fixed-width AX attributes, most significant field first as stored in the payload.
  typedef struct packed {
    logic [3:0] cache;
    logic [2:0] prot;
    logic       lock;
    logic [1:0] burst;
    logic [2:0] size;
    logic [7:0] len;
    logic [3:0] qos;
    logic [3:0] region;
  } ax_attr_t;

  function automatic int ax_payload_w(input int id_w, input int addr_w, input int user_w,
                                      input bit is_aw);
    return AX_FIXED_W + addr_w + user_w + id_w + (is_aw ? ATOP_W : 0);
  endfunction

endpackage

// File: rtl/axi_ax_fifo.sv
// Valid/ready FIFO with occupancy output and an optional zero-latency fall-through path
// used when the FIFO is empty.
module axi_ax_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     usage
);

  localparam int UW    = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [UW-1:0]    FULL_CNT = UW'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic                  ready_en;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [UW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass;
  logic write;
  logic read;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = ready_en & ~full;
  assign push      = in_valid & in_ready;
  // Bypass only once out of reset so master data reads as zero while held in reset.
  assign bypass    = FALL_THROUGH & empty & in_valid & ready_en;
  assign out_valid = ~empty | bypass;
  assign out_data  = bypass ? in_data : mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign write     = push & ~(bypass & out_ready);
  assign read      = pop & ~empty;
  assign usage     = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (write) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (read) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({write, read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so nothing from an interrupted transfer can reappear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/axi_ax_buffer.sv
// AXI4 AR/AW address-channel elastic buffer: packs the AX beat into a FIFO payload and unpacks it.
// Define AXI_AX_BUFFER_STALL_CNT_EN to add stall_clr_i/stall_cnt_o (saturating master-stall counter).
module axi_ax_buffer
  import axi_ax_buffer_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 2,
  parameter bit IS_AW        = 1'b0,
  parameter bit FALL_THROUGH = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                test_en_i,
  input  logic                                slave_valid_i,
  input  logic [ADDR_WIDTH-1:0]               slave_addr_i,
  input  logic [2:0]                          slave_prot_i,
  input  logic [3:0]                          slave_region_i,
  input  logic [7:0]                          slave_len_i,
  input  logic [2:0]                          slave_size_i,
  input  logic [1:0]                          slave_burst_i,
  input  logic                                slave_lock_i,
  input  logic [3:0]                          slave_cache_i,
  input  logic [3:0]                          slave_qos_i,
  input  logic [5:0]                          slave_atop_i,
  input  logic [ID_WIDTH-1:0]                 slave_id_i,
  input  logic [USER_WIDTH-1:0]               slave_user_i,
  output logic                                slave_ready_o,
  output logic                                master_valid_o,
  output logic [ADDR_WIDTH-1:0]               master_addr_o,
  output logic [2:0]                          master_prot_o,
  output logic [3:0]                          master_region_o,
  output logic [7:0]                          master_len_o,
  output logic [2:0]                          master_size_o,
  output logic [1:0]                          master_burst_o,
  output logic                                master_lock_o,
  output logic [3:0]                          master_cache_o,
  output logic [3:0]                          master_qos_o,
  output logic [5:0]                          master_atop_o,
  output logic [ID_WIDTH-1:0]                 master_id_o,
  output logic [USER_WIDTH-1:0]               master_user_o,
  input  logic                                master_ready_i,
`ifdef AXI_AX_BUFFER_STALL_CNT_EN
  input  logic                                stall_clr_i,
  output logic [15:0]                         stall_cnt_o,
`endif
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   usage_o
);

  localparam int PAYLOAD_W = ax_payload_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH, IS_AW);
  localparam int CORE_W    = AX_FIXED_W + ADDR_WIDTH + USER_WIDTH + ID_WIDTH;

  if (BUFFER_DEPTH < 1) begin : g_bad_depth
    $error("axi_ax_buffer: BUFFER_DEPTH must be at least 1");
  end

  ax_attr_t             slave_attr;
  ax_attr_t             master_attr;
  logic [CORE_W-1:0]    slave_core;
  logic [CORE_W-1:0]    master_core;
  logic [PAYLOAD_W-1:0] slave_payload;
  logic [PAYLOAD_W-1:0] master_payload;
  logic                 unused_test_en;

  assign unused_test_en = test_en_i;

  assign slave_attr = '{
    cache:  slave_cache_i,
    prot:   slave_prot_i,
    lock:   slave_lock_i,
    burst:  slave_burst_i,
    size:   slave_size_i,
    len:    slave_len_i,
    qos:    slave_qos_i,
    region: slave_region_i
  };
  assign slave_core = {slave_attr, slave_addr_i, slave_user_i, slave_id_i};

  assign {master_attr, master_addr_o, master_user_o, master_id_o} = master_core;
  assign master_cache_o  = master_attr.cache;
  assign master_prot_o   = master_attr.prot;
  assign master_lock_o   = master_attr.lock;
  assign master_burst_o  = master_attr.burst;
  assign master_size_o   = master_attr.size;
  assign master_len_o    = master_attr.len;
  assign master_qos_o    = master_attr.qos;
  assign master_region_o = master_attr.region;

  // ATOP rides in the low payload bits on AW; on AR it is neither stored nor forwarded.
  if (IS_AW) begin : g_aw
    assign slave_payload = {slave_core, slave_atop_i};
    assign master_core   = master_payload[PAYLOAD_W-1:ATOP_W];
    assign master_atop_o = master_payload[ATOP_W-1:0];
  end else begin : g_ar
    logic unused_atop;
    assign unused_atop   = ^slave_atop_i;
    assign slave_payload = slave_core;
    assign master_core   = master_payload;
    assign master_atop_o = '0;
  end

  axi_ax_fifo #(
    .DATA_WIDTH  (PAYLOAD_W),
    .DEPTH       (BUFFER_DEPTH),
    .FALL_THROUGH(FALL_THROUGH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_valid (slave_valid_i),
    .in_data  (slave_payload),
    .in_ready (slave_ready_o),
    .out_valid(master_valid_o),
    .out_data (master_payload),
    .out_ready(master_ready_i),
    .usage    (usage_o)
  );

`ifdef AXI_AX_BUFFER_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Counts cycles the master side holds off a valid beat; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (stall_clr_i) begin
      stall_cnt <= '0;
    end else if (master_valid_o && !master_ready_i && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule
